// File: rtl/cpe_pkg.sv
// Shared types and helpers for the convolution MAC engine: FSM states,
// accumulator sizing and signed saturation.
package cpe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    REDUCE,
    DONE
  } state_t;

  // Saturation works on a fixed wide container so one function serves any OUT_WIDTH.
  localparam int SAT_W = 128;

  typedef struct packed {
    logic                    ovf;
    logic signed [SAT_W-1:0] value;
  } sat_t;

  function automatic int acc_width(input int data_w, input int taps, input int channels);
    return 2 * data_w + $clog2(taps * channels) + 1;
  endfunction

  function automatic sat_t saturate(input logic signed [SAT_W-1:0] value, input int out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t                    res;
    max_v     = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    min_v     = ~max_v;
    res.ovf   = 1'b0;
    res.value = value;
    if (value > max_v) begin
      res.ovf   = 1'b1;
      res.value = max_v;
    end else if (value < min_v) begin
      res.ovf   = 1'b1;
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/cpe_mac_lane.sv
// One channel lane: tap-indexed operand select, full-precision signed multiply
// and a wide accumulator with clear and enable.
module cpe_mac_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 9,
  parameter int TAP_W      = $clog2(TAPS),
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS) + 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [TAP_W-1:0]             tap,
  input  logic [TAPS*DATA_WIDTH-1:0]   a_flat,
  input  logic [TAPS*DATA_WIDTH-1:0]   b_flat,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [DATA_WIDTH-1:0]   a_sel;
  logic signed [DATA_WIDTH-1:0]   b_sel;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;

  always_comb begin
    a_sel = a_flat[tap*DATA_WIDTH +: DATA_WIDTH];
    b_sel = b_flat[tap*DATA_WIDTH +: DATA_WIDTH];
    prod  = a_sel * b_sel;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cpe_mac_engine.sv
// Convolution processing element: captures a KxK window/kernel bundle per channel,
// accumulates sequentially, then applies bias, optional reduction, ReLU and saturation.
module cpe_mac_engine
  import cpe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1,
  parameter int OUT_WIDTH   = 32,
  localparam int TAPS       = KERNEL_SIZE * KERNEL_SIZE,
  parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, KERNEL_SIZE * KERNEL_SIZE, CHANNELS),
  parameter int TAP_W       = $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CHANNELS*TAPS*DATA_WIDTH-1:0] multiplier_input,
  input  logic [CHANNELS*TAPS*DATA_WIDTH-1:0] multiplicand_input,
  input  logic [OUT_WIDTH-1:0]                bias,
  input  logic                                relu_en,
  input  logic                                reduce_en,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0]       out_sum,
  output logic [CHANNELS-1:0]                 out_ovf
);

  state_t                              state_q;
  logic [TAP_W-1:0]                    tap_q;
  logic [CHANNELS*TAPS*DATA_WIDTH-1:0] a_q;
  logic [CHANNELS*TAPS*DATA_WIDTH-1:0] b_q;
  logic [OUT_WIDTH-1:0]                bias_q;
  logic                                relu_q;
  logic                                reduce_q;
  logic                                out_valid_q;
  logic [CHANNELS*OUT_WIDTH-1:0]       out_sum_q;
  logic [CHANNELS-1:0]                 out_ovf_q;
  logic                                accept;
  logic signed [ACC_WIDTH-1:0]         acc [CHANNELS];

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid;

  // Operand capture: the bundle is frozen at acceptance so inputs may change freely afterwards.
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_q      <= multiplier_input;
      b_q      <= multiplicand_input;
      bias_q   <= bias;
      relu_q   <= relu_en;
      reduce_q <= reduce_en;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    cpe_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAPS      (TAPS),
      .TAP_W     (TAP_W),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .Clk   (Clk),
      .Rst   (Rst),
      .clr   (accept),
      .en    (state_q == MAC),
      .tap   (tap_q),
      .a_flat(a_q[c*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH]),
      .b_flat(b_q[c*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH]),
      .acc   (acc[c])
    );
  end

  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   lane_sum;
  logic signed [ACC_WIDTH-1:0]   r;
  logic [CHANNELS*OUT_WIDTH-1:0] red_sum;
  logic [CHANNELS-1:0]           red_ovf;
  sat_t                          sat;

  // ReLU precedes saturation, so a clamped negative never reports overflow.
  always_comb begin
    bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_q[OUT_WIDTH-1]}}, bias_q};
    lane_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_sum = lane_sum + acc[c];
    end
    red_sum = '0;
    red_ovf = '0;
    r       = '0;
    sat     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (reduce_q) begin
        r = (c == 0) ? lane_sum + bias_ext : '0;
      end else begin
        r = acc[c] + bias_ext;
      end
      if (relu_q && r < 0) begin
        r = '0;
      end
      sat = saturate({{(SAT_W-ACC_WIDTH){r[ACC_WIDTH-1]}}, r}, OUT_WIDTH);
      red_sum[c*OUT_WIDTH +: OUT_WIDTH] = sat.value[OUT_WIDTH-1:0];
      red_ovf[c] = sat.ovf;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= MAC;
            tap_q   <= '0;
          end
        end
        MAC: begin
          tap_q <= tap_q + 1'b1;
          if (tap_q == TAP_W'(TAPS - 1)) begin
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          out_sum_q   <= red_sum;
          out_ovf_q   <= red_ovf;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cpe_mac_engine.sv
// Directed scoreboard bench for cpe_mac_engine (K=3, C=2, 16-bit operands and results).
module tb_cpe_mac_engine;

  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int TAPS = K * K;
  localparam int C    = 2;
  localparam int OW   = 16;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [C*TAPS*DW-1:0]  mult;
  logic [C*TAPS*DW-1:0]  mcand;
  logic [OW-1:0]         bias;
  logic                  relu_en;
  logic                  reduce_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [C*OW-1:0]       out_sum;
  logic [C-1:0]          out_ovf;

  typedef struct packed {
    logic [C*OW-1:0] sum;
    logic [C-1:0]    ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  cpe_mac_engine #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .CHANNELS   (C),
    .OUT_WIDTH  (OW)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .multiplier_input  (mult),
    .multiplicand_input(mcand),
    .bias              (bias),
    .relu_en           (relu_en),
    .reduce_en         (reduce_en),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_sum           (out_sum),
    .out_ovf           (out_ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int a, input int b);
    logic [DW-1:0] av;
    logic [DW-1:0] bv;
    av = a[DW-1:0];
    bv = b[DW-1:0];
    for (int c = 0; c < C; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        mult[(c*TAPS+t)*DW +: DW]  = av;
        mcand[(c*TAPS+t)*DW +: DW] = bv;
      end
    end
  endtask

  function automatic exp_t model();
    longint acc [C];
    longint total;
    longint r;
    exp_t   e;
    e     = '0;
    total = 0;
    for (int c = 0; c < C; c++) begin
      acc[c] = 0;
      for (int t = 0; t < TAPS; t++) begin
        acc[c] += longint'($signed(mult[(c*TAPS+t)*DW +: DW])) *
                  longint'($signed(mcand[(c*TAPS+t)*DW +: DW]));
      end
      total += acc[c];
    end
    for (int c = 0; c < C; c++) begin
      if (reduce_en) r = (c == 0) ? total + longint'($signed(bias)) : 0;
      else           r = acc[c] + longint'($signed(bias));
      if (relu_en && r < 0) r = 0;
      if (r > 32767) begin
        r = 32767;
        e.ovf[c] = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        e.ovf[c] = 1'b1;
      end
      e.sum[c*OW +: OW] = r[OW-1:0];
    end
    return e;
  endfunction

  // Present the current operands and return just after the acceptance edge.
  task automatic send(input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_accept_wait"}, 64'(n < 100), 64'(1));
    sb_q.push_back(model());
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit ack);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(TAPS + 1));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      chk({tag, "_sum"}, 64'(out_sum), 64'(e.sum));
      chk({tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
    end
    if (ack) begin
      out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
      chk({tag, "_ready_back"}, 64'(in_ready), 64'(1));
    end
  endtask

  initial begin
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mult      = '0;
    mcand     = '0;
    bias      = '0;
    relu_en   = 1'b0;
    reduce_en = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));

    fill(1, 2);
    send("basic");
    wait_result("basic", 1'b1);
    chk("basic_value", 64'(last_exp.sum), 64'({16'd18, 16'd18}));

    reduce_en = 1'b1;
    bias      = -16'sd5;
    send("reduce");
    wait_result("reduce", 1'b1);
    chk("reduce_value", 64'(last_exp.sum), 64'({16'd0, 16'd31}));

    reduce_en = 1'b0;
    bias      = '0;
    fill(-1, 3);
    send("neg");
    wait_result("neg", 1'b1);
    chk("neg_value", 64'(last_exp.sum), 64'({16'hFFE5, 16'hFFE5}));
    relu_en = 1'b1;
    send("relu");
    wait_result("relu", 1'b1);

    relu_en = 1'b0;
    fill(32767, 32767);
    send("sat_pos");
    wait_result("sat_pos", 1'b1);
    chk("sat_pos_value", 64'({last_exp.sum, last_exp.ovf}), 64'({16'h7FFF, 16'h7FFF, 2'b11}));
    fill(32767, -32768);
    send("sat_neg");
    wait_result("sat_neg", 1'b1);
    relu_en = 1'b1;
    send("sat_relu");
    wait_result("sat_relu", 1'b1);
    relu_en = 1'b0;

    // Backpressure: result held while a new bundle waits, then accepted after release.
    fill(2, 3);
    send("bp_a");
    fill(7, 1);
    wait_result("bp_a", 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("bp_hold_sum", 64'(out_sum), 64'(last_exp.sum));
      chk("bp_hold_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    send("bp_b");
    wait_result("bp_b", 1'b1);
    chk("bp_b_value", 64'(last_exp.sum), 64'({16'd63, 16'd63}));
    repeat (14) @(posedge Clk);
    #1;
    chk("bp_no_extra", 64'(out_valid), 64'(0));
    chk("bp_sb_empty", 64'(sb_q.size()), 64'(0));

    // Reset mid-accumulation discards the bundle.
    fill(5, 5);
    send("rst_mid");
    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    void'(sb_q.pop_back());
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_ready", 64'(in_ready), 64'(1));
    chk("rst_mid_sum", 64'(out_sum), 64'(0));
    chk("rst_mid_ovf", 64'(out_ovf), 64'(0));
    fill(1, 2);
    send("post_rst");
    wait_result("post_rst", 1'b1);
    chk("post_rst_value", 64'(last_exp.sum), 64'({16'd18, 16'd18}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpe_mac_engine.md
# cpe_mac_engine

Parametrised convolution processing element: accepts one flattened K×K window plus K×K kernel per channel over a valid/ready handshake, performs a sequential signed multiply-accumulate per channel, adds bias, optionally reduces across channels and applies ReLU, then saturates to the output width. It sits between the block-design operand connectors and the cSum/cReady result path. It generalises the fixed 3×3 integer processor with:
- arbitrary kernel size and channel count;
- bias, ReLU and channel-reduction modes;
- saturation with overflow flags;
- full backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, signed operand width (integer only).
- KERNEL_SIZE, 3, kernel edge K; TAPS = K*K.
- CHANNELS, 1, independent lanes C.
- OUT_WIDTH, 32, signed result width per lane.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(TAPS*CHANNELS)+1, internal accumulator width; never wraps.
- TAP_W, $clog2(TAPS), tap counter width.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset; dominates every other input.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  engine can accept a bundle (high only in IDLE).
- multiplier_input  in  C*TAPS*DATA_WIDTH  flat operands; lane c, tap t at bits [(c*TAPS+t)*DATA_WIDTH +: DATA_WIDTH].
- multiplicand_input  in  C*TAPS*DATA_WIDTH  kernel weights, same layout.
- bias  in  OUT_WIDTH  signed bias, sign-extended into the accumulator.
- relu_en  in  1  clamp negative results to 0.
- reduce_en  in  1  0: per-lane results; 1: sum of all lanes in lane 0, other lanes 0.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_sum  out  C*OUT_WIDTH  signed results.
- out_ovf  out  C  per-lane saturation flag.

## Operation
- FSM states: IDLE, MAC, REDUCE, DONE.
- IDLE: in_ready=1.
  - On in_valid, capture both operand buses plus bias, relu_en and reduce_en into registers.
  - Clear the accumulators, set tap=0, go to MAC.
  - Inputs may change after acceptance without effect.
- MAC: each cycle, every lane does acc[c] += sext(a[c][tap]) * sext(b[c][tap]), full-precision signed, then tap++.
  - On the cycle tap==TAPS-1, go to REDUCE.
- REDUCE: one cycle.
  - reduce_en=0: r[c] = acc[c] + bias.
  - reduce_en=1: r[0] = Σacc[c] + bias, r[c>0] = 0.
  - If relu_en and r<0, then r=0.
  - Saturate to the signed OUT_WIDTH range. out_ovf[c]=1 if clipping occurred.
  - Register out_sum and out_ovf, go to DONE.
- DONE: out_valid=1. out_sum and out_ovf stay stable while out_ready=0.
  - On out_ready, go to IDLE.
- ReLU is applied before saturation, so a negative overflow under ReLU yields 0 with ovf=0.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_sum=0, out_ovf=0, accumulators=0, tap=0.
- Rst in any state: on the next edge, return to IDLE and discard the captured bundle. No partial result is ever emitted.

## Timing
- Acceptance edge = cycle 0. MAC occupies edges 1..TAPS. REDUCE is at edge TAPS+1. out_valid is high after edge TAPS+1 (for 3×3: 10 cycles after acceptance).
- Handshake transfer occurs on any edge where valid and ready are both high.
- With out_ready tied high, out_valid is a one-cycle pulse. Next in_ready is one cycle later. Throughput is one bundle per TAPS+3 cycles.
- in_ready is low in MAC, REDUCE and DONE. in_valid in those states is ignored, not queued.
- relu_en and reduce_en take effect only at acceptance.

## Structure
- Package cpe_pkg holds:
  - the state enum;
  - the ACC_WIDTH computation function;
  - a saturate(value, OUT_WIDTH) → {ovf, result} function.
- Sub-module cpe_mac_lane: one signed multiplier + accumulator, with tap-indexed operand mux and clear/enable inputs. It is generated CHANNELS times.
- Top-level holds the FSM, tap counter, reduction/bias/ReLU/saturate stage and output registers.

## Test plan
- K=3, C=2, DW=8, all multipliers 1, multiplicands 2, reduce_en=0, bias=0 → out_sum={18,18}, ovf=0, out_valid exactly 10 cycles after acceptance.
- Same operands, reduce_en=1, bias=-5 → lane0=31, lane1=0.
- Multipliers -1, multiplicands 3, reduce_en=0: relu_en=0 → {-27,-27}; relu_en=1 → {0,0}.
- DW=16, OUT_WIDTH=16, all operands 32767 → lane=32767, ovf=1. Multiplicands -32768, multipliers 32767 → -32768, ovf=1.
- Hold out_ready=0 for 5 cycles with in_valid=1 and new operands → out_sum stable, in_ready=0, no second acceptance. Raise out_ready → IDLE next cycle, then the new bundle is accepted.
- Assert Rst at MAC tap 4 → next cycle state IDLE, out_valid=0, out_sum=0, in_ready=1. A following bundle produces a correct result with no residue from the first.
